pc_unit: RTL and testbench

- Parametrised program-counter unit for the MIPS core; next generation of the single-width PC register.
- Generalises address width, reset vector, target base offset and branch polarity (beq/bne); adds a fetch stall and a call/return address stack (RAS).
- Sits at the head of the fetch stage. Drives the instruction-memory address and pc_plus4 to the decode/link path.

---
 rtl/pc_unit.sv | 174 +++++++++++++++++
 tb/tb_pc_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit at the head of the MIPS fetch stage.
// Selects the next fetch address from sequential, conditional branch
// (beq/bne), jump, call (jump+link) and return. Returns are served from a
// small circular return-address stack (RAS). If the stack is empty, the
// address comes from the register file instead.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   : a misaligned next-pc is refused and align_fault latches (sticky)
//   undefined : targets load unchecked, align_fault tied low
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   stall          hold pc and RAS, ignore control inputs this cycle
//   branch_flag    conditional branch; branch_ne selects bne/beq sense
//   zero_flag      ALU zero result
//   branch_offset  signed, pre-shifted byte offset
//   jmp_flag       unconditional jump to jmp_address + BASE
//   jmp_address    jump target (relative to BASE)
//   link           with jmp_flag: call, push pc+4 onto RAS
//   ret_flag       return; ret_address + BASE is used on an empty RAS
//   pc             current fetch address (registered)
//   pc_plus4       pc + 4 (combinational)
//   ras_count      number of valid RAS entries
//   ras_miss       one-cycle pulse after a return served from ret_address
//   align_fault    sticky misalignment flag (see macro above)
module pc_unit #(
   parameter int unsigned       WIDTH        = 32,
   parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(32'h31b0),
   parameter logic [WIDTH-1:0]  BASE         = WIDTH'(32'h31b0),
   parameter int unsigned       RAS_DEPTH    = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic                             branch_flag,
   input  logic                             branch_ne,
   input  logic                             zero_flag,
   input  logic [WIDTH-1:0]                 branch_offset,
   input  logic                             jmp_flag,
   input  logic [WIDTH-1:0]                 jmp_address,
   input  logic                             link,
   input  logic                             ret_flag,
   input  logic [WIDTH-1:0]                 ret_address,
   output logic [WIDTH-1:0]                 pc,
   output logic [WIDTH-1:0]                 pc_plus4,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
   output logic                             ras_miss,
   output logic                             align_fault
);

   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   // RAS storage; wr_ptr is the next free slot, so the top of stack sits one below it
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_inc;
   logic [PTR_W-1:0] top_ptr;

   logic [WIDTH-1:0] tgt;
   logic             tgt_push;
   logic             tgt_pop;
   logic             tgt_miss;
   logic             taken;
   logic             advance;

   logic [WIDTH-1:0] pc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [PTR_W-1:0] ptr_nxt;
   logic             miss_nxt;
   logic             push;

   assign pc_plus4   = pc + WIDTH'(4);
   assign wr_ptr_inc = (wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
   assign top_ptr    = (wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr - PTR_W'(1);
   assign taken      = branch_ne ? ~zero_flag : zero_flag;

   // Candidate target by priority: branch > return > jump > sequential
   always_comb begin
      tgt      = pc_plus4;
      tgt_push = 1'b0;
      tgt_pop  = 1'b0;
      tgt_miss = 1'b0;
      if (branch_flag) begin
         if (taken) begin
            tgt = pc_plus4 + branch_offset + BASE;
         end
      end else if (ret_flag) begin
         if (ras_count != '0) begin
            tgt     = ras_mem[top_ptr];
            tgt_pop = 1'b1;
         end else begin
            tgt      = ret_address + BASE;
            tgt_miss = 1'b1;
         end
      end else if (jmp_flag) begin
         tgt      = jmp_address + BASE;
         tgt_push = link;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic fault_nxt;
   logic misaligned;

   assign misaligned = (tgt[1:0] != 2'b00);

   // A misaligned target is refused and faults; once faulted, everything freezes
   always_comb begin
      fault_nxt = align_fault;
      advance   = ~stall & ~align_fault & ~misaligned;
      if (~stall && ~align_fault && misaligned) begin
         fault_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         align_fault <= 1'b0;
      end else begin
         align_fault <= fault_nxt;
      end
   end
`else
   assign advance     = ~stall;
   assign align_fault = 1'b0;
`endif

   // Next state: pc, stack pointer/count and miss pulse
   always_comb begin
      pc_nxt   = pc;
      cnt_nxt  = ras_count;
      ptr_nxt  = wr_ptr;
      miss_nxt = 1'b0;
      push     = 1'b0;
      if (advance) begin
         pc_nxt   = tgt;
         miss_nxt = tgt_miss;
         if (tgt_push) begin
            push    = 1'b1;
            ptr_nxt = wr_ptr_inc;
            // full stack: the push overwrites the oldest entry, count saturates
            if (ras_count != CNT_W'(RAS_DEPTH)) begin
               cnt_nxt = ras_count + CNT_W'(1);
            end
         end else if (tgt_pop) begin
            ptr_nxt = top_ptr;
            cnt_nxt = ras_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc        <= RESET_VECTOR;
         ras_count <= '0;
         wr_ptr    <= '0;
         ras_miss  <= 1'b0;
      end else begin
         pc        <= pc_nxt;
         ras_count <= cnt_nxt;
         wr_ptr    <= ptr_nxt;
         ras_miss  <= miss_nxt;
      end
   end

   // Stack contents need no reset; validity is tracked by ras_count
   always_ff @(posedge clk) begin
      if (push) begin
         ras_mem[wr_ptr] <= pc_plus4;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, table-driven bench for pc_unit (default parameters).
// Each table row optionally resets, drives one cycle of control inputs and
// compares pc, pc_plus4, ras_count, ras_miss and align_fault after the edge.
// Asynchronous reset, stall and alignment cases are hand-written sequences.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, branch_flag, branch_ne, zero_flag;
   logic [31:0] branch_offset;
   logic        jmp_flag, link, ret_flag;
   logic [31:0] jmp_address, ret_address;
   logic [31:0] pc, pc_plus4;
   logic [2:0]  ras_count;
   logic        ras_miss, align_fault;

   int errors = 0;
   int checks = 0;

   pc_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_flag   (branch_flag),
      .branch_ne     (branch_ne),
      .zero_flag     (zero_flag),
      .branch_offset (branch_offset),
      .jmp_flag      (jmp_flag),
      .jmp_address   (jmp_address),
      .link          (link),
      .ret_flag      (ret_flag),
      .ret_address   (ret_address),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .ras_count     (ras_count),
      .ras_miss      (ras_miss),
      .align_fault   (align_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   typedef struct {
      bit          do_rst;
      bit          s, br, bne, z;
      logic [31:0] off;
      bit          j, l, r;
      logic [31:0] ja, ra;
      logic [31:0] epc;
      int          ecnt;
      bit          emiss;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit do_rst, input bit s, input bit br, input bit bne,
                               input bit z, input logic [31:0] off, input bit j, input bit l,
                               input bit r, input logic [31:0] ja, input logic [31:0] ra,
                               input logic [31:0] epc, input int ecnt, input bit emiss);
      vec_t v;
      v.do_rst = do_rst; v.s = s; v.br = br; v.bne = bne; v.z = z; v.off = off;
      v.j = j; v.l = l; v.r = r; v.ja = ja; v.ra = ra;
      v.epc = epc; v.ecnt = ecnt; v.emiss = emiss;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (step %0d): got %h required %h", name, idx, got, exp);
      end
   endtask

   task automatic idle_inputs();
      stall = 0; branch_flag = 0; branch_ne = 0; zero_flag = 0; branch_offset = '0;
      jmp_flag = 0; link = 0; ret_flag = 0; jmp_address = '0; ret_address = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic check_all(input string tag, input int idx, input logic [31:0] epc,
                            input int ecnt, input bit emiss, input bit efault);
      check({tag, " pc"}, idx, pc, epc);
      check({tag, " pc_plus4"}, idx, pc_plus4, epc + 32'd4);
      check({tag, " ras_count"}, idx, 32'(ras_count), 32'(ecnt));
      check({tag, " ras_miss"}, idx, 32'(ras_miss), 32'(emiss));
      check({tag, " align_fault"}, idx, 32'(align_fault), 32'(efault));
   endtask

   task automatic apply(input vec_t v);
      stall = v.s; branch_flag = v.br; branch_ne = v.bne; zero_flag = v.z;
      branch_offset = v.off; jmp_flag = v.j; link = v.l; ret_flag = v.r;
      jmp_address = v.ja; ret_address = v.ra;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      rst = 1'b1;
      idle_inputs();
      #3;
      check_all("reset", 0, 32'h31b0, 0, 0, 0);
      rst = 1'b0;

      // idle sequence, then async reset mid-cycle with a live stack entry
      for (int i = 1; i <= 3; i++) begin
         v = '{default: '0};
         apply(v);
         check_all("idle", i, 32'h31b0 + 32'(4 * i), 0, 0, 0);
      end
      v = '{default: '0};
      v.j = 1; v.l = 1; v.ja = 32'h100;
      apply(v);
      check_all("call before reset", 0, 32'h32b0, 1, 0, 0);
      idle_inputs();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all("async reset", 0, 32'h31b0, 0, 0, 0);
      #1;
      rst = 1'b0;

      // do_rst s br bne z off j l r ja ra -> pc cnt miss
      add(1, 0, 1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 32'h6374, 0, 0);
      add(1, 0, 1, 1, 1, 32'h10, 0, 0, 0, 0, 0, 32'h31b4, 0, 0);
      add(1, 0, 1, 0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h6374, 0, 0);
      add(1, 0, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 32'h31b4, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100, 0, 32'h32b0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 32'h31b8, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40, 32'h31f0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h31f4, 0, 0);
      add(0, 0, 1, 0, 1, 32'hffffce50, 0, 0, 0, 0, 0, 32'h31f8, 0, 0);
      // five nested calls into a 4-deep stack, then five returns
      add(1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1000, 0, 32'h41b0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h2000, 0, 32'h51b0, 2, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h3000, 0, 32'h61b0, 3, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h4000, 0, 32'h71b0, 4, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h5000, 0, 32'h81b0, 4, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8, 32'h71b4, 3, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8, 32'h61b4, 2, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8, 32'h51b4, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8, 32'h41b4, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8, 32'h31b8, 0, 1);
      // priority: branch over jump+link, branch over ret, ret over jump+link
      add(1, 0, 1, 1, 1, 32'h10, 1, 1, 0, 32'h100, 0, 32'h31b4, 0, 0);
      add(0, 0, 1, 0, 1, 32'h0, 0, 0, 1, 0, 32'h20, 32'h6368, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 32'h20, 32'h31d0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0, 32'h31c0, 0, 0);
      // stall holds everything, then the held jump+link happens once
      add(0, 1, 0, 0, 0, 0, 1, 1, 0, 32'h100, 0, 32'h31c0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 1, 1, 0, 32'h100, 0, 32'h31c0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100, 0, 32'h32b0, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h32b4, 1, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h32b4, 1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h31c4, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 32'h80, 32'h31c4, 0, 0);

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         apply(vecs[i]);
         check_all("vec", i, vecs[i].epc, vecs[i].ecnt, vecs[i].emiss, 0);
      end

      // misaligned jump target
      do_reset();
      v = '{default: '0};
      v.j = 1; v.ja = 32'h2;
      apply(v);
`ifdef PC_ALIGN_CHECK_EN
      check_all("align jump", 0, 32'h31b0, 0, 0, 1);
      v = '{default: '0};
      apply(v);
      check_all("align sticky", 0, 32'h31b0, 0, 0, 1);
      v.j = 1; v.l = 1; v.ja = 32'h100;
      apply(v);
      check_all("align frozen", 0, 32'h31b0, 0, 0, 1);
      do_reset();
      check_all("align cleared", 0, 32'h31b0, 0, 0, 0);
`else
      check_all("align jump", 0, 32'h31b2, 0, 0, 0);
      v = '{default: '0};
      apply(v);
      check_all("align next", 0, 32'h31b6, 0, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
